// File: rtl/memory_access_block.sv
// memory_access_block: MEM stage of the pipelined Thumb core.
// Takes the EX/MEM register outputs and performs loads and stores over a
// req/ack data-memory bus whose latency varies. Upstream is stalled while an
// access is in flight, and the MEM/WB register is written with the result.
//
// Ports
//   clk_i, reset_i            clock, asynchronous active-high reset
//   is_valid_i .. reg_2_data_i EX/MEM register contents (control enums, Thumb
//                              opA/opB for size and sign decode, destination
//                              register, effective address or ALU result,
//                              store data)
//   stall_o                   upstream holds the EX/MEM register this cycle
//   dmem_*                    data-memory bus: req, we, word address, byte
//                              enables, lane-replicated store data, ack,
//                              read data
//   fault_o                   1-cycle pulse on a misaligned access or a bus
//                              timeout
//   is_valid_o .. reg_data_o  MEM/WB register

package memory_access_block_pkg;
  localparam int WORD       = 32;
  localparam int ADDR_WIDTH = 4;

  typedef enum logic {MEM_WRITE_DIS = 1'b0, MEM_WRITE_EN = 1'b1} mem_write_signal;
  typedef enum logic {REG_FILE_WRITE_DIS = 1'b0, REG_FILE_WRITE_EN = 1'b1} reg_file_write_sig;
  typedef enum logic {DATA_SRC_ALU = 1'b0, DATA_SRC_MEM = 1'b1} reg_file_data_source;

  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} acc_size_e;
endpackage

module memory_access_block
  import memory_access_block_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  is_valid_i,
  input  mem_write_signal       mem_write_en_i,
  input  reg_file_write_sig     reg_file_write_en_i,
  input  reg_file_data_source   reg_file_data_source_i,
  input  logic [6:0]            opA_opB_i,
  input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
  input  logic [WORD-1:0]       alu_result_i,
  input  logic [WORD-1:0]       reg_2_data_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [WORD-1:0]       dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [WORD-1:0]       dmem_wdata_o,
  input  logic                  dmem_ack_i,
  input  logic [WORD-1:0]       dmem_rdata_i,
  output logic                  fault_o,
  output logic                  is_valid_o,
  output reg_file_write_sig     reg_file_write_en_o,
  output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
  output logic [WORD-1:0]       reg_data_o
);
  localparam int NUM_LANES = 4;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

  state_e state_q, state_d;

  // ---- size / sign decode from the Thumb opcode fields
  logic [3:0] op_a;
  logic [2:0] op_b;
  acc_size_e  size;
  logic       sext;
  assign op_a = opA_opB_i[6:3];
  assign op_b = opA_opB_i[2:0];

  always_comb begin
    size = SZ_WORD;
    sext = 1'b0;
    case (op_a)
      4'b0101: begin
        case (op_b)
          3'b001, 3'b101: size = SZ_HALF;
          3'b111:         begin size = SZ_HALF; sext = 1'b1; end
          3'b010, 3'b110: size = SZ_BYTE;
          3'b011:         begin size = SZ_BYTE; sext = 1'b1; end
          default:        size = SZ_WORD;
        endcase
      end
      4'b0111: size = SZ_BYTE;
      4'b1000: size = SZ_HALF;
      default: size = SZ_WORD;
    endcase
  end

  logic is_store, is_load, mem_op, misalign;
  assign is_store = is_valid_i && (mem_write_en_i == MEM_WRITE_EN);
  assign is_load  = is_valid_i && (reg_file_data_source_i == DATA_SRC_MEM);
  assign mem_op   = is_store || is_load;
  assign misalign = ((size == SZ_HALF) && alu_result_i[0]) ||
                    ((size == SZ_WORD) && (alu_result_i[1:0] != 2'b00));

  // ---- store lanes: enable and data per byte lane
  logic [NUM_LANES-1:0]       be_c;
  logic [NUM_LANES-1:0][7:0]  wd_c;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LI = 2'(l);
    assign be_c[l] = (size == SZ_BYTE) ? (alu_result_i[1:0] == LI) :
                     (size == SZ_HALF) ? (alu_result_i[1] == LI[1]) : 1'b1;
    assign wd_c[l] = (size == SZ_BYTE) ? reg_2_data_i[7:0] :
                     (size == SZ_HALF) ? reg_2_data_i[8*(l%2) +: 8] :
                                         reg_2_data_i[8*l +: 8];
  end

  // ---- access latched on entry to REQ, held stable until ack
  logic [WORD-1:0]       a_addr, a_wdata;
  logic [3:0]            a_be;
  logic                  a_we, a_sext;
  acc_size_e             a_size;
  logic [ADDR_WIDTH-1:0] a_dest;
  reg_file_write_sig     a_wen;
  logic [7:0]            to_cnt;

  // ---- load extract (only meaningful in the ack cycle)
  logic [NUM_LANES-1:0][7:0] rd_lane;
  logic [7:0]                rd_b;
  logic [15:0]               rd_h;
  logic [WORD-1:0]           ld_data;
  assign rd_lane = dmem_rdata_i;
  assign rd_b    = rd_lane[a_addr[1:0]];
  assign rd_h    = a_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    case (a_size)
      SZ_BYTE: ld_data = {{24{a_sext & rd_b[7]}}, rd_b};
      SZ_HALF: ld_data = {{16{a_sext & rd_h[15]}}, rd_h};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  // ---- next state, stall and MEM/WB update
  logic                  stall_c, accept, cnt_inc, fault_d;
  logic                  wb_vld;
  reg_file_write_sig     wb_wen;
  logic [ADDR_WIDTH-1:0] wb_dest;
  logic [WORD-1:0]       wb_data;

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    accept  = 1'b0;
    cnt_inc = 1'b0;
    fault_d = 1'b0;
    wb_vld  = 1'b0;
    wb_wen  = REG_FILE_WRITE_DIS;
    wb_dest = reg_dest_addr_o;
    wb_data = reg_data_o;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          if (misalign) begin
            fault_d = 1'b1;
          end else begin
            stall_c = 1'b1;
            accept  = 1'b1;
            state_d = S_REQ;
          end
        end else begin
          wb_vld  = is_valid_i;
          wb_wen  = is_valid_i ? reg_file_write_en_i : REG_FILE_WRITE_DIS;
          wb_dest = reg_dest_addr_i;
          wb_data = alu_result_i;
        end
      end
      S_REQ: begin
        if (dmem_ack_i) begin
          wb_vld  = 1'b1;
          wb_wen  = a_we ? REG_FILE_WRITE_DIS : a_wen;
          wb_dest = a_dest;
          wb_data = a_we ? a_addr : ld_data;
          state_d = S_IDLE;
        end else if (to_cnt == TO_LAST) begin
          // give up: release upstream and drop the instruction
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q             <= S_IDLE;
      to_cnt              <= '0;
      a_addr              <= '0;
      a_wdata             <= '0;
      a_be                <= '0;
      a_we                <= 1'b0;
      a_sext              <= 1'b0;
      a_size              <= SZ_WORD;
      a_dest              <= '0;
      a_wen               <= REG_FILE_WRITE_DIS;
      fault_o             <= 1'b0;
      is_valid_o          <= 1'b0;
      reg_file_write_en_o <= REG_FILE_WRITE_DIS;
      reg_dest_addr_o     <= '0;
      reg_data_o          <= '0;
    end else begin
      state_q <= state_d;
      fault_o <= fault_d;
      if (accept) begin
        to_cnt  <= '0;
        a_addr  <= alu_result_i;
        a_wdata <= wd_c;
        a_be    <= be_c;
        a_we    <= is_store;
        a_sext  <= sext;
        a_size  <= size;
        a_dest  <= reg_dest_addr_i;
        a_wen   <= reg_file_write_en_i;
      end else if (cnt_inc) begin
        to_cnt <= to_cnt + 8'd1;
      end
      is_valid_o          <= wb_vld;
      reg_file_write_en_o <= wb_wen;
      reg_dest_addr_o     <= wb_dest;
      reg_data_o          <= wb_data;
    end
  end

  // bus signals derive from the state register so reset drops req at once
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = dmem_req_o & a_we;
  assign dmem_be_o    = dmem_req_o ? a_be : 4'h0;
  assign dmem_addr_o  = {a_addr[WORD-1:2], 2'b00};
  assign dmem_wdata_o = a_wdata;
  assign stall_o      = stall_c & ~reset_i;

endmodule
